// File: rtl/cmp_pkg.sv
// cmp_pkg: shared definitions for the serial magnitude comparator.
//   - State encoding for the serial_cmp control FSM.
//   - width_ok(): legality check that the operand width splits into
//     whole DIGIT-bit slices (used as an elaboration-time guard).
package cmp_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_e;

    function automatic bit width_ok(input int width, input int digit);
        return (digit > 0) && (width >= digit) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/cmp_slice.sv
// cmp_slice: combinational DIGIT-bit unsigned magnitude comparator.
// Ports:
//   a, b  in  DIGIT  slice operands
//   lt    out 1      a <  b
//   gt    out 1      a >  b
//   eq    out 1      a == b
module cmp_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    always_comb begin
        eq = (a == b);
        lt = (a < b);
        gt = (a > b);
    end

endmodule

// File: rtl/serial_cmp.sv
// serial_cmp: sequential magnitude comparator. Compares two WIDTH-bit
// operands DIGIT bits per clock, most significant slice first, and stops
// at the first differing slice. Signed (two's complement) or unsigned
// order is chosen per operation.
// Ports:
//   clk          in  1      clock, rising edge
//   rst          in  1      synchronous active-high reset
//   start        in  1      request; accepted in IDLE or in the DONE cycle
//   signed_mode  in  1      1 = signed compare, captured with start
//   num1, num2   in  WIDTH  operands, captured with start
//   busy         out 1      comparison in progress
//   done         out 1      one-cycle pulse, result valid
//   lt, gt, eq   out 1      result flags, held until the next accepted start
module serial_cmp
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

    generate
        if (!width_ok(WIDTH, DIGIT)) begin : g_bad_width
            $error("serial_cmp: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   op1_q,   op1_d;
    logic [WIDTH-1:0]   op2_q,   op2_d;
    logic               sgn_q,   sgn_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic               lt_q,    lt_d;
    logic               gt_q,    gt_d;
    logic               eq_q,    eq_d;

    logic [DIGIT-1:0]   sl_a, sl_b;
    logic               sl_lt, sl_gt, sl_eq;

    // Top slice of the shifted operands. On slice 0 in signed mode the sign
    // bits are flipped so two's-complement order becomes unsigned order;
    // lower slices are plain magnitude digits.
    always_comb begin
        sl_a = op1_q[WIDTH-1 -: DIGIT];
        sl_b = op2_q[WIDTH-1 -: DIGIT];
        if (sgn_q && (cnt_q == '0)) begin
            sl_a[DIGIT-1] = ~sl_a[DIGIT-1];
            sl_b[DIGIT-1] = ~sl_b[DIGIT-1];
        end
    end

    cmp_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .a  (sl_a),
        .b  (sl_b),
        .lt (sl_lt),
        .gt (sl_gt),
        .eq (sl_eq)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        sgn_d   = sgn_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        lt_d    = lt_q;
        gt_d    = gt_q;
        eq_d    = eq_q;

        unique case (state_q)
            // IDLE and the DONE cycle both accept a new request, which gives
            // back-to-back operation without an idle bubble.
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (start) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    op1_d   = num1;
                    op2_d   = num2;
                    sgn_d   = signed_mode;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                end
            end

            ST_RUN: begin
                if (!sl_eq) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    lt_d    = sl_lt;
                    gt_d    = sl_gt;
                    eq_d    = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    eq_d    = 1'b1;
                end else begin
                    op1_d = op1_q << DIGIT;
                    op2_d = op2_q << DIGIT;
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Operand registers carry data only and need no reset; everything that
    // steers control or is visible on the ports is reset.
    always_ff @(posedge clk) begin
        op1_q <= op1_d;
        op2_q <= op2_d;
        sgn_q <= sgn_d;
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign lt   = lt_q;
    assign gt   = gt_q;
    assign eq   = eq_q;

endmodule

// File: tb/tb_serial_cmp.sv
// tb_serial_cmp: self-checking bench for serial_cmp with directed cases
// and randomized operations checked against an arithmetic reference model.
module tb_serial_cmp;

    localparam int WIDTH  = 16;
    localparam int DIGIT  = 4;
    localparam int NSLICE = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] num1, num2;
    logic             busy, done, lt, gt, eq;

    int n_chk  = 0;
    int n_fail = 0;

    // Expected outcome of the operation currently in flight.
    logic e_lt, e_gt, e_eq;
    int   e_lat;

    serial_cmp #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .num1        (num1),
        .num2        (num2),
        .busy        (busy),
        .done        (done),
        .lt          (lt),
        .gt          (gt),
        .eq          (eq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: ordering from plain (signed or unsigned) arithmetic; latency
    // is the index of the first differing slice from the top, plus one, or
    // NSLICE when the operands are equal.
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        bit found;
        e_eq = (a == b);
        if (s) e_lt = ($signed(a) < $signed(b));
        else   e_lt = (a < b);
        e_gt  = !e_lt && !e_eq;
        e_lat = NSLICE;
        found = 1'b0;
        for (int k = 0; k < NSLICE; k++) begin
            if (!found && (a[WIDTH-1-k*DIGIT -: DIGIT] != b[WIDTH-1-k*DIGIT -: DIGIT])) begin
                found = 1'b1;
                e_lat = k + 1;
            end
        end
    endtask

    // Drive a request for one edge, then scramble the inputs: anything after
    // acceptance must not influence the result.
    task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        model(a, b, s);
        num1        = a;
        num2        = b;
        signed_mode = s;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        num1        = WIDTH'($urandom);
        num2        = WIDTH'($urandom);
        signed_mode = 1'($urandom);
        chk("accept_busy", {31'd0, busy}, 32'd1);
        chk("accept_done", {31'd0, done}, 32'd0);
        chk("accept_clear", {29'd0, lt, gt, eq}, 32'd0);
    endtask

    // n0 = edges already elapsed since the accepting edge.
    task automatic wait_done(input string tag, input int n0);
        int n;
        n = n0;
        while (done !== 1'b1 && n < 40) begin
            chk({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
            tick();
            n++;
        end
        if (done !== 1'b1) chk({tag, "_timeout"}, 32'd0, 32'd1);
        chk({tag, "_lat"}, n, e_lat);
        chk({tag, "_res"}, {29'd0, lt, gt, eq}, {29'd0, e_lt, e_gt, e_eq});
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic after_done(input string tag);
        tick();
        chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_hold"}, {29'd0, lt, gt, eq}, {29'd0, e_lt, e_gt, e_eq});
    endtask

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             s;
    } op_t;

    op_t dir_ops[5];

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        num1        = '0;
        num2        = '0;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_res", {29'd0, lt, gt, eq}, 32'd0);

        // Reset wins over start.
        start = 1'b1;
        num1  = 16'h0001;
        tick();
        chk("rst_prio_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);

        dir_ops[0] = '{16'h1234, 16'h1235, 1'b0};
        dir_ops[1] = '{16'hA000, 16'h0FFF, 1'b0};
        dir_ops[2] = '{16'hA000, 16'h0FFF, 1'b1};
        dir_ops[3] = '{16'hBEEF, 16'hBEEF, 1'b0};
        dir_ops[4] = '{16'hFFFF, 16'hFFFF, 1'b1};
        foreach (dir_ops[i]) begin
            accept(dir_ops[i].a, dir_ops[i].b, dir_ops[i].s);
            wait_done($sformatf("dir%0d", i), 0);
            after_done($sformatf("dir%0d", i));
        end

        // start pulsed again mid-RUN with different operands: ignored.
        accept(16'h1234, 16'h1235, 1'b0);
        tick();
        num1  = 16'hFFFF;
        num2  = 16'h0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ignore", 2);
        after_done("ignore");

        // Reset during the third RUN cycle discards the operation.
        accept(16'h1234, 16'h1235, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_res", {29'd0, lt, gt, eq}, 32'd0);
        tick();
        chk("midrst_idle_done", {31'd0, done}, 32'd0);
        accept(16'h8000, 16'h7FFF, 1'b1);
        wait_done("postrst", 0);
        after_done("postrst");

        // New request accepted in the DONE cycle.
        accept(16'h1234, 16'h1234, 1'b0);
        wait_done("b2b_first", 0);
        accept(16'h0001, 16'h0000, 1'b0);
        wait_done("b2b_second", 0);
        after_done("b2b_second");

        // Randomized operations; operand pairs are biased to share upper
        // slices so every latency is exercised. Some are issued in the
        // DONE cycle, others after idle gaps.
        for (int r = 0; r < 200; r++) begin
            logic [WIDTH-1:0] a, b, mask;
            int keep;
            a    = WIDTH'($urandom);
            keep = int'($urandom_range(0, NSLICE));
            mask = (keep == NSLICE) ? '0 : (WIDTH'({WIDTH{1'b1}}) >> (keep * DIGIT));
            b    = a ^ (WIDTH'($urandom) & mask);
            accept(a, b, 1'($urandom));
            wait_done("rand", 0);
            if ($urandom_range(0, 1) == 0) begin
                after_done("rand");
                repeat ($urandom_range(0, 2)) tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
